// File: rtl/pong_pkg.sv
// Shared definitions for the pong design.
// Contents:
//   debounce_state_t        - per-button debounce FSM states
//   DEFAULT_DEBOUNCE_CYCLES - default qualification time (10 ms at CLK_HZ)
//   CLK_HZ                  - system pixel clock frequency
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;

endpackage

// File: rtl/btn_debounce.sv
// Single-channel button conditioner: two-flop synchronizer followed by a
// four-state debounce FSM with a qualification counter.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   raw     - raw asynchronous button level (active-high)
//   db      - registered debounced level (1 in PRESSED / RELEASE_WAIT)
//   pressed - registered one-cycle pulse when a press is accepted
module btn_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic pressed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            s1;
  logic            s2;
  debounce_state_t state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; the FSM only ever looks at s2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce FSM. The wait states leave at CNT_LAST, so cnt never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      db      <= 1'b0;
      pressed <= 1'b0;
    end else begin
      pressed <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state   <= PRESSED;
            db      <= 1'b1;
            pressed <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high returns to PRESSED without a new pulse.
          if (s2) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            db    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          db    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_input_cond.sv
// Paddle button conditioner: debounces the up/down push-buttons of one
// player and resolves the both-held case before the levels reach the paddle.
// Ports:
//   clk          - system pixel clock
//   rst_n        - asynchronous active-low reset
//   btn_up_raw   - raw up button (active-high, asynchronous)
//   btn_down_raw - raw down button (active-high, asynchronous)
//   up, down     - conditioned, mutually exclusive levels to the paddle
//   up_pressed   - one-cycle pulse on an accepted up press (never masked)
//   down_pressed - one-cycle pulse on an accepted down press (never masked)
// Build option:
//   PADDLE_LAST_WINS_EN - when defined, the most recently accepted button
//   wins while both are held (up wins a same-edge tie); otherwise both
//   held drives both outputs low.
module paddle_input_cond
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic up,
  output logic down,
  output logic up_pressed,
  output logic down_pressed
);

  logic db_up;
  logic db_down;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (btn_up_raw),
    .db     (db_up),
    .pressed(up_pressed)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (btn_down_raw),
    .db     (db_down),
    .pressed(down_pressed)
  );

`ifdef PADDLE_LAST_WINS_EN
  // last: 1 = up most recently accepted, 0 = down.
  logic last;
  logic last_now;

  // The press pulses rise on the same edge as db, so folding them in here
  // lets the winner take effect on the very edge its db rises.
  always_comb begin
    last_now = last;
    if (up_pressed) begin
      last_now = 1'b1;
    end else if (down_pressed) begin
      last_now = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b0;
    end else begin
      last <= last_now;
    end
  end

  assign up   = db_up   & (~db_down | last_now);
  assign down = db_down & (~db_up   | ~last_now);
`else
  assign up   = db_up   & ~db_down;
  assign down = db_down & ~db_up;
`endif

endmodule

// File: tb/tb_paddle_input_cond.sv
// Testbench for paddle_input_cond with DEBOUNCE_CYCLES=16.
// The reference model treats each channel as "the debounced level flips
// once the synchronized input has disagreed with it for N+1 consecutive
// samples", with the synchronized input being the raw level two edges late.
// Define PADDLE_LAST_WINS_EN for both DUT and bench to test that build.
module tb_paddle_input_cond;
  import pong_pkg::*;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up_raw = 1'b0;
  logic btn_down_raw = 1'b0;
  logic up, down, up_pressed, down_pressed;

  int errors = 0;
  int checks = 0;
  int edge_no = 0;

  // reference model state
  logic mu_d1, mu_d2, md_d1, md_d2;
  logic m_db_up, m_db_dn, m_pu, m_pd, m_last;
  int   run_up, run_dn;

  always #5 clk = ~clk;

  paddle_input_cond #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up_raw  (btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .up          (up),
    .down        (down),
    .up_pressed  (up_pressed),
    .down_pressed(down_pressed)
  );

  task automatic model_reset();
    mu_d1 = 0; mu_d2 = 0; md_d1 = 0; md_d2 = 0;
    m_db_up = 0; m_db_dn = 0; m_pu = 0; m_pd = 0; m_last = 0;
    run_up = 0; run_dn = 0;
  endtask

  task automatic chan_step(input logic s, inout logic db, inout int run,
                           output logic pulse);
    pulse = 1'b0;
    if (s != db) begin
      run++;
      if (run == N + 1) begin
        db = s;
        pulse = s;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic check_outputs();
    logic exp_up, exp_dn;
`ifdef PADDLE_LAST_WINS_EN
    exp_up = m_db_up & (~m_db_dn | m_last);
    exp_dn = m_db_dn & (~m_db_up | ~m_last);
`else
    exp_up = m_db_up & ~m_db_dn;
    exp_dn = m_db_dn & ~m_db_up;
`endif
    checks++;
    assert (up === exp_up) else begin
      errors++;
      $error("FAIL up: observed=%b expected=%b edge=%0d", up, exp_up, edge_no);
    end
    checks++;
    assert (down === exp_dn) else begin
      errors++;
      $error("FAIL down: observed=%b expected=%b edge=%0d", down, exp_dn, edge_no);
    end
    checks++;
    assert (up_pressed === m_pu) else begin
      errors++;
      $error("FAIL up_pressed: observed=%b expected=%b edge=%0d", up_pressed, m_pu, edge_no);
    end
    checks++;
    assert (down_pressed === m_pd) else begin
      errors++;
      $error("FAIL down_pressed: observed=%b expected=%b edge=%0d", down_pressed, m_pd, edge_no);
    end
  endtask

  // One clock edge: advance the model with the levels the DUT sampled,
  // then check the outputs 1 time unit later.
  task automatic tick();
    logic su, sd;
    @(posedge clk);
    edge_no++;
    if (rst_n) begin
      su = mu_d2; sd = md_d2;
      mu_d2 = mu_d1; mu_d1 = btn_up_raw;
      md_d2 = md_d1; md_d1 = btn_down_raw;
      chan_step(su, m_db_up, run_up, m_pu);
      chan_step(sd, m_db_dn, run_dn, m_pd);
      if (m_pu) m_last = 1'b1;
      else if (m_pd) m_last = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    run(2);
    rst_n = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    int pulse_edge;
    int rem_u, rem_d;
    model_reset();
    // reset state
    #1 check_outputs();
    run(3);
    rst_n = 1'b1;
    edge_no = 0;

    // 1: up held from edge 10, single pulse at edge 28
    pulse_edge = -1;
    run(9);
    btn_up_raw = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (up_pressed && pulse_edge < 0) pulse_edge = edge_no;
    end
    checks++;
    assert (pulse_edge === 28) else begin
      errors++;
      $error("FAIL pulse_edge: observed=%0d expected=28", pulse_edge);
    end
    btn_up_raw = 1'b0;
    run(25);

    // 2: 15 high / 1 low bursts never qualify, then a sustained hold does
    for (int r = 0; r < 5; r++) begin
      btn_up_raw = 1'b1; run(15);
      btn_up_raw = 1'b0; run(1);
    end
    btn_up_raw = 1'b1; run(30);

    // 3: short drop is absorbed, sustained drop releases
    btn_up_raw = 1'b0; run(10);
    btn_up_raw = 1'b1; run(10);
    btn_up_raw = 1'b0; run(25);

    // 4: both held, down accepted 12 edges after up
    btn_up_raw = 1'b1; run(12);
    btn_down_raw = 1'b1; run(30);
    btn_down_raw = 1'b0; run(25);
    btn_up_raw = 1'b0; run(25);

    // 5: reset at cycle 8 of PRESS_WAIT, then full requalification
    btn_up_raw = 1'b1; run(10);
    async_reset();
    run(30);
    btn_up_raw = 1'b0; run(25);

    // 6: both rise on the same edge
    btn_up_raw = 1'b1; btn_down_raw = 1'b1; run(25);
    btn_up_raw = 1'b0; btn_down_raw = 1'b0; run(25);

    // randomized bouncing on both channels, with one reset in the middle
    rem_u = 0; rem_d = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rem_u == 0) begin
        btn_up_raw = ~btn_up_raw;
        rem_u = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                            : int'($urandom_range(10, 40));
      end
      if (rem_d == 0) begin
        btn_down_raw = ~btn_down_raw;
        rem_d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                            : int'($urandom_range(10, 40));
      end
      rem_u--; rem_d--;
      if (i == 700) async_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
